// File: rtl/meter_ctrl_pkg.sv
// Shared encodings and counter widths for the taxi-meter mode controller.
// Widths are sized from the production defaults so every counter holds its limit.
package meter_pkg;

   typedef enum logic [1:0] {
      ST_VACANT = 2'b00,
      ST_DRIVE  = 2'b01,
      ST_WAIT   = 2'b10,
      ST_SETTLE = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      DISP_PRICE = 2'b00,
      DISP_DIST  = 2'b01,
      DISP_WAIT  = 2'b10
   } disp_t;

   localparam int CNT_MAX_DEF  = 999_999;
   localparam int IDLE_TMO_DEF = 49_999_999;
   localparam int SEC_MAX_DEF  = 49_999_999;
   localparam int DISP_SEC_DEF = 5;

   localparam int CNT_W  = $clog2(CNT_MAX_DEF + 1);
   localparam int TMO_W  = $clog2(IDLE_TMO_DEF + 1);
   localparam int SEC_W  = $clog2(SEC_MAX_DEF + 1);
   localparam int DISP_W = $clog2(DISP_SEC_DEF + 1);

   function automatic disp_t next_disp(input disp_t cur);
      case (cur)
         DISP_PRICE: next_disp = DISP_DIST;
         DISP_DIST:  next_disp = DISP_WAIT;
         default:    next_disp = DISP_PRICE;
      endcase
   endfunction

endpackage

// File: rtl/meter_ctrl_if.sv
// Control bundle from the mode controller (master) to the fare datapath (slave).
interface meter_ctrl_if;
   import meter_pkg::*;

   logic   dist_pulse;
   logic   wait_tick;
   logic   fare_clr;
   logic   fare_hold;
   disp_t  disp_sel;
   state_t state;
   logic   stat_led;

   modport master (
      output dist_pulse, wait_tick, fare_clr, fare_hold, disp_sel, state, stat_led
   );

   modport slave (
      input dist_pulse, wait_tick, fare_clr, fare_hold, disp_sel, state, stat_led
   );

endinterface

// File: rtl/meter_ctrl_key_filter.sv
// Two-flop synchronizer plus counter debounce for an idle-high push button.
// Emits a single-cycle press on each debounced 1->0 transition; release is silent.
module key_filter
   import meter_pkg::*;
#(
   parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_DEF)
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_key,
   output logic o_press
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;
   logic             w_settled;

   assign w_settled = (r_sync2 != r_stable) && (r_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
      end
   end

   // Any sample that agrees with the stable level restarts the qualification window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable <= 1'b1;
         r_cnt    <= '0;
         r_press  <= 1'b0;
      end else begin
         r_press <= w_settled & r_stable;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (w_settled) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/meter_ctrl.sv
// Taxi-meter mode controller: trip FSM, wheel-pulse conditioning, wait-second
// ticks and display-source rotation driving the fare datapath.
module meter_ctrl
   import meter_pkg::*;
#(
   parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CNT_MAX_DEF),
   parameter logic [TMO_W-1:0]  IDLE_TMO = TMO_W'(IDLE_TMO_DEF),
   parameter logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(SEC_MAX_DEF),
   parameter logic [DISP_W-1:0] DISP_SEC = DISP_W'(DISP_SEC_DEF)
)(
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic         stat_port,
   input  logic         pulse_port,
   meter_ctrl_if.master bus
);

   state_t              r_state;
   state_t              w_next;
   logic                w_press;
   logic                r_psync1;
   logic                r_psync2;
   logic                r_pprev;
   logic                w_pulse_rise;
   logic [TMO_W-1:0]    r_idle;
   logic [SEC_W-1:0]    r_wsec;
   logic [SEC_W-1:0]    r_fsec;
   logic [DISP_W-1:0]   r_disp_cnt;
   disp_t               r_disp;
   logic                r_dist;
   logic                r_wtick;
   logic                r_clr;
   logic                r_hold;
   logic                r_led;
   logic                w_idle_tmo;
   logic                w_sec_tick;
   logic                w_hired_next;

   key_filter #(.CNT_MAX(CNT_MAX)) u_key_filter (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .i_key   (stat_port),
      .o_press (w_press)
   );

   // Edge-detect flop resets high too, so an idle-low wheel never fakes a rise.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_psync1 <= 1'b1;
         r_psync2 <= 1'b1;
         r_pprev  <= 1'b1;
      end else begin
         r_psync1 <= pulse_port;
         r_psync2 <= r_psync1;
         r_pprev  <= r_psync2;
      end
   end

   assign w_pulse_rise = r_psync2 & ~r_pprev;
   assign w_idle_tmo   = (r_state == ST_DRIVE) && (r_idle == IDLE_TMO);
   assign w_sec_tick   = (r_fsec == SEC_MAX);
   assign w_hired_next = (w_next == ST_DRIVE) || (w_next == ST_WAIT);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= ST_VACANT;
      else            r_state <= w_next;
   end

   // The button outranks every other event in every state.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_VACANT: if (w_press) w_next = ST_DRIVE;
         ST_DRIVE: begin
            if (w_press)         w_next = ST_SETTLE;
            else if (w_idle_tmo) w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_press)           w_next = ST_SETTLE;
            else if (w_pulse_rise) w_next = ST_DRIVE;
         end
         ST_SETTLE: if (w_press) w_next = ST_VACANT;
         default:   w_next = ST_VACANT;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_idle <= '0;
         r_wsec <= '0;
         r_fsec <= '0;
      end else begin
         r_idle <= (r_state == ST_DRIVE && w_next == ST_DRIVE && !w_pulse_rise) ?
                   r_idle + 1'b1 : '0;
         if (r_state == ST_WAIT && w_next == ST_WAIT)
            r_wsec <= (r_wsec == SEC_MAX) ? '0 : r_wsec + 1'b1;
         else
            r_wsec <= '0;
         r_fsec <= w_sec_tick ? '0 : r_fsec + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_dist  <= 1'b0;
         r_wtick <= 1'b0;
         r_clr   <= 1'b0;
         r_hold  <= 1'b0;
         r_led   <= 1'b0;
      end else begin
         r_dist  <= w_pulse_rise && (r_state == ST_DRIVE || r_state == ST_WAIT);
         r_wtick <= (r_state == ST_WAIT) && (r_wsec == SEC_MAX);
         r_clr   <= (r_state == ST_VACANT) && (w_next == ST_DRIVE);
         r_hold  <= (w_next == ST_SETTLE);
         case (w_next)
            ST_VACANT: r_led <= 1'b0;
            ST_SETTLE: r_led <= (r_state != ST_SETTLE) ? 1'b1 :
                                (w_sec_tick ? ~r_led : r_led);
            default:   r_led <= 1'b1;
         endcase
      end
   end

   // Unhired states park the display on price so every trip starts there.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_disp     <= DISP_PRICE;
         r_disp_cnt <= '0;
      end else if (w_hired_next) begin
         if (w_sec_tick) begin
            if (r_disp_cnt == DISP_SEC - 1'b1) begin
               r_disp     <= next_disp(r_disp);
               r_disp_cnt <= '0;
            end else begin
               r_disp_cnt <= r_disp_cnt + 1'b1;
            end
         end
      end else begin
         r_disp     <= DISP_PRICE;
         r_disp_cnt <= '0;
      end
   end

   assign bus.dist_pulse = r_dist;
   assign bus.wait_tick  = r_wtick;
   assign bus.fare_clr   = r_clr;
   assign bus.fare_hold  = r_hold;
   assign bus.disp_sel   = r_disp;
   assign bus.state      = r_state;
   assign bus.stat_led   = r_led;

endmodule

// File: tb/tb_meter_ctrl.sv
// Directed bench for meter_ctrl with shortened timing constants.
module tb_meter_ctrl;
   import meter_pkg::*;

   localparam int CNT_MAX_TB  = 49;
   localparam int IDLE_TMO_TB = 999;
   localparam int SEC_TB      = 100;
   localparam int DISP_SEC_TB = 2;
   // Two synchronizer stages plus the edge-detect clock before the rise takes effect.
   localparam int PULSE_LAT   = 3;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   logic stat_port;
   logic pulse_port;

   int checks   = 0;
   int failures = 0;
   int totDist  = 0;
   int totTick  = 0;
   int totClr   = 0;
   int measPress = 0;
   int measTmo   = 0;

   meter_ctrl_if bus ();

   meter_ctrl #(
      .CNT_MAX  (CNT_W'(CNT_MAX_TB)),
      .IDLE_TMO (TMO_W'(IDLE_TMO_TB)),
      .SEC_MAX  (SEC_W'(SEC_TB - 1)),
      .DISP_SEC (DISP_W'(DISP_SEC_TB))
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .stat_port  (stat_port),
      .pulse_port (pulse_port),
      .bus        (bus)
   );

   always #10 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (bus.dist_pulse) totDist++;
      if (bus.wait_tick)  totTick++;
      if (bus.fare_clr)   totClr++;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic waitForState(input logic [1:0] target, input int budget, output int took);
      took = -1;
      for (int k = 1; k <= budget; k++) begin
         @(posedge sys_clk);
         #1;
         if (bus.state == target) begin
            took = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0; stat_port = 1'b1; pulse_port = 1'b0;
      cyc(3);
      checks++; if (bus.state !== 2'b00) begin failures++; $display("[TB] FAIL rst_state got %b want 00", bus.state); end
      checks++; if (bus.fare_clr !== 1'b0) begin failures++; $display("[TB] FAIL rst_clr got %b want 0", bus.fare_clr); end
      checks++; if (bus.fare_hold !== 1'b0) begin failures++; $display("[TB] FAIL rst_hold got %b want 0", bus.fare_hold); end
      checks++; if (bus.disp_sel !== 2'b00) begin failures++; $display("[TB] FAIL rst_disp got %b want 00", bus.disp_sel); end
      checks++; if (bus.stat_led !== 1'b0) begin failures++; $display("[TB] FAIL rst_led got %b want 0", bus.stat_led); end
      checks++; if (bus.dist_pulse !== 1'b0 || bus.wait_tick !== 1'b0) begin failures++; $display("[TB] FAIL rst_pulses got %b%b want 00", bus.dist_pulse, bus.wait_tick); end
      sys_rst_n = 1'b1;
      cyc(5);
      checks++; if (bus.state !== 2'b00 || totClr !== 0) begin failures++; $display("[TB] FAIL post_rst got state %b clr %0d want 00/0", bus.state, totClr); end
   endtask

   task automatic test_press_drive();
      int clr0;
      clr0 = totClr;
      for (int i = 0; i < 10; i++) begin
         stat_port = (i % 2 == 0) ? 1'b0 : 1'b1;
         #100;
      end
      stat_port = 1'b0;
      #2000;
      checks++; if (bus.state !== 2'b01) begin failures++; $display("[TB] FAIL press_state got %b want 01", bus.state); end
      checks++; if (totClr - clr0 !== 1) begin failures++; $display("[TB] FAIL press_clr_count got %0d want 1", totClr - clr0); end
      checks++; if (bus.stat_led !== 1'b1) begin failures++; $display("[TB] FAIL press_led got %b want 1", bus.stat_led); end
      stat_port = 1'b1;
      cyc(100);
      checks++; if (bus.state !== 2'b01 || totClr - clr0 !== 1) begin failures++; $display("[TB] FAIL release_event got state %b clr %0d want 01/1", bus.state, totClr - clr0); end
   endtask

   task automatic test_distance();
      int d0;
      d0 = totDist;
      for (int i = 0; i < 10; i++) begin
         pulse_port = 1'b1; cyc(100);
         pulse_port = 1'b0; cyc(100);
         checks++; if (bus.state !== 2'b01) begin failures++; $display("[TB] FAIL dist_state[%0d] got %b want 01", i, bus.state); end
      end
      checks++; if (totDist - d0 !== 10) begin failures++; $display("[TB] FAIL dist_count got %0d want 10", totDist - d0); end
   endtask

   task automatic test_wait();
      int took, t0, d0;
      int tickAt[$];
      pulse_port = 1'b1;
      waitForState(2'b10, 1200, took);
      measTmo = took;
      pulse_port = 1'b0;
      checks++; if (took !== PULSE_LAT + IDLE_TMO_TB + 1) begin failures++; $display("[TB] FAIL idle_timeout got %0d want %0d", took, PULSE_LAT + IDLE_TMO_TB + 1); end
      t0 = totTick;
      for (int k = 1; k <= 250; k++) begin
         cyc(1);
         if (bus.wait_tick) tickAt.push_back(k);
      end
      checks++; if (tickAt.size() !== 2) begin failures++; $display("[TB] FAIL wait_tick_count got %0d want 2", tickAt.size()); end
      else begin
         checks++; if (tickAt[0] !== SEC_TB || tickAt[1] !== 2 * SEC_TB) begin failures++; $display("[TB] FAIL wait_tick_pos got %0d,%0d want %0d,%0d", tickAt[0], tickAt[1], SEC_TB, 2 * SEC_TB); end
      end
      d0 = totDist;
      pulse_port = 1'b1;
      waitForState(2'b01, 10, took);
      checks++; if (took !== PULSE_LAT) begin failures++; $display("[TB] FAIL wait_to_drive got %0d want %0d", took, PULSE_LAT); end
      cyc(150);
      pulse_port = 1'b0;
      checks++; if (totDist - d0 !== 1) begin failures++; $display("[TB] FAIL wake_dist got %0d want 1", totDist - d0); end
      checks++; if (totTick - t0 !== 2) begin failures++; $display("[TB] FAIL no_third_tick got %0d want 2", totTick - t0); end
   endtask

   task automatic test_settle();
      int took, d0, nTog, prevLed;
      int togAt[$];
      waitForState(2'b10, 1200, took);
      checks++; if (took < 0) begin failures++; $display("[TB] FAIL reach_wait got timeout want state 10"); end
      stat_port = 1'b0;
      waitForState(2'b11, 200, took);
      measPress = took;
      checks++; if (took < CNT_MAX_TB + 1 || took > CNT_MAX_TB + 6) begin failures++; $display("[TB] FAIL settle_latency got %0d want %0d..%0d", took, CNT_MAX_TB + 1, CNT_MAX_TB + 6); end
      stat_port = 1'b1;
      checks++; if (bus.fare_hold !== 1'b1) begin failures++; $display("[TB] FAIL settle_hold got %b want 1", bus.fare_hold); end
      checks++; if (bus.disp_sel !== 2'b00) begin failures++; $display("[TB] FAIL settle_disp got %b want 00", bus.disp_sel); end
      checks++; if (bus.stat_led !== 1'b1) begin failures++; $display("[TB] FAIL settle_led_entry got %b want 1", bus.stat_led); end
      d0 = totDist;
      prevLed = bus.stat_led;
      for (int k = 1; k <= 350; k++) begin
         if (k % 100 == 20) pulse_port = 1'b1;
         if (k % 100 == 30) pulse_port = 1'b0;
         cyc(1);
         if (bus.stat_led !== prevLed) togAt.push_back(k);
         prevLed = bus.stat_led;
      end
      nTog = togAt.size();
      checks++; if (nTog < 3) begin failures++; $display("[TB] FAIL led_toggles got %0d want >=3", nTog); end
      else begin
         checks++; if (togAt[0] > SEC_TB || togAt[1] - togAt[0] !== SEC_TB || togAt[2] - togAt[1] !== SEC_TB) begin
            failures++; $display("[TB] FAIL led_period got %0d,%0d,%0d want first<=%0d then +%0d", togAt[0], togAt[1], togAt[2], SEC_TB, SEC_TB);
         end
      end
      checks++; if (totDist - d0 !== 0) begin failures++; $display("[TB] FAIL settle_dist got %0d want 0", totDist - d0); end
      checks++; if (bus.state !== 2'b11) begin failures++; $display("[TB] FAIL settle_stay got %b want 11", bus.state); end
      stat_port = 1'b0;
      waitForState(2'b00, 200, took);
      stat_port = 1'b1;
      checks++; if (bus.state !== 2'b00 || bus.fare_hold !== 1'b0 || bus.stat_led !== 1'b0) begin
         failures++; $display("[TB] FAIL vacant_return got state %b hold %b led %b want 00/0/0", bus.state, bus.fare_hold, bus.stat_led);
      end
      cyc(80);
   endtask

   task automatic test_display();
      int took, clr0;
      int chAt[$];
      logic [1:0] chVal[$];
      logic [1:0] prevSel;
      clr0 = totClr;
      stat_port = 1'b0;
      waitForState(2'b01, 200, took);
      stat_port = 1'b1;
      checks++; if (bus.disp_sel !== 2'b00) begin failures++; $display("[TB] FAIL disp_entry got %b want 00", bus.disp_sel); end
      prevSel = bus.disp_sel;
      for (int k = 1; k <= 650; k++) begin
         cyc(1);
         if (bus.disp_sel !== prevSel) begin
            chAt.push_back(k);
            chVal.push_back(bus.disp_sel);
         end
         prevSel = bus.disp_sel;
      end
      checks++; if (totClr - clr0 !== 1) begin failures++; $display("[TB] FAIL disp_clr got %0d want 1", totClr - clr0); end
      checks++; if (chAt.size() !== 3) begin failures++; $display("[TB] FAIL disp_changes got %0d want 3", chAt.size()); end
      else begin
         checks++; if (chVal[0] !== 2'b01 || chVal[1] !== 2'b10 || chVal[2] !== 2'b00) begin
            failures++; $display("[TB] FAIL disp_seq got %b,%b,%b want 01,10,00", chVal[0], chVal[1], chVal[2]);
         end
         checks++; if (chAt[0] > DISP_SEC_TB * SEC_TB || chAt[1] - chAt[0] !== DISP_SEC_TB * SEC_TB || chAt[2] - chAt[1] !== DISP_SEC_TB * SEC_TB) begin
            failures++; $display("[TB] FAIL disp_period got %0d,%0d,%0d want first<=200 then +200", chAt[0], chAt[1], chAt[2]);
         end
      end
   endtask

   task automatic test_reset_midwait();
      int took, clr0;
      waitForState(2'b10, 1200, took);
      checks++; if (took < 0) begin failures++; $display("[TB] FAIL reach_wait2 got timeout want state 10"); end
      cyc(30);
      clr0 = totClr;
      #5;
      sys_rst_n = 1'b0;
      #1;
      checks++; if (bus.state !== 2'b00) begin failures++; $display("[TB] FAIL arst_state got %b want 00", bus.state); end
      checks++; if (bus.stat_led !== 1'b0) begin failures++; $display("[TB] FAIL arst_led got %b want 0", bus.stat_led); end
      checks++; if (bus.disp_sel !== 2'b00 || bus.fare_hold !== 1'b0) begin failures++; $display("[TB] FAIL arst_disp_hold got %b/%b want 00/0", bus.disp_sel, bus.fare_hold); end
      checks++; if (bus.dist_pulse !== 1'b0 || bus.wait_tick !== 1'b0 || bus.fare_clr !== 1'b0) begin failures++; $display("[TB] FAIL arst_pulses got %b%b%b want 000", bus.dist_pulse, bus.wait_tick, bus.fare_clr); end
      cyc(3);
      sys_rst_n = 1'b1;
      cyc(20);
      checks++; if (bus.state !== 2'b00 || totClr - clr0 !== 0) begin failures++; $display("[TB] FAIL arst_after got state %b clr %0d want 00/0", bus.state, totClr - clr0); end
   endtask

   task automatic test_press_vs_timeout();
      int took, lead;
      stat_port = 1'b0;
      waitForState(2'b01, 200, took);
      stat_port = 1'b1;
      cyc(100);
      lead = measTmo - measPress;
      pulse_port = 1'b1;
      cyc(lead);
      stat_port = 1'b0;
      cyc(measPress - 1);
      checks++; if (bus.state !== 2'b01) begin failures++; $display("[TB] FAIL coinc_before got %b want 01", bus.state); end
      cyc(1);
      checks++; if (bus.state !== 2'b11) begin failures++; $display("[TB] FAIL coinc_state got %b want 11", bus.state); end
      checks++; if (bus.fare_hold !== 1'b1) begin failures++; $display("[TB] FAIL coinc_hold got %b want 1", bus.fare_hold); end
      stat_port = 1'b1;
      pulse_port = 1'b0;
      cyc(10);
   endtask

   initial begin
      $display("[TB] meter_ctrl directed test start");
      test_reset();
      test_press_drive();
      test_distance();
      test_wait();
      test_settle();
      test_display();
      test_reset_midwait();
      test_press_vs_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/meter_ctrl.md
Name: meter_ctrl

Overview:
Mode controller and scheduler for the taxi-meter fare datapath (data_gen). It debounces the state button and conditions the wheel pulse. It runs the VACANT / DRIVE / WAIT / SETTLE trip state machine and issues the enables, clear, hold and per-second wait ticks that sequence the fare accumulators. It also rotates the 6-digit display source between price, distance and wait time.

Parameters:
CNT_MAX, 999_999, debounce stable-count for stat_port (20 ms at 50 MHz)
IDLE_TMO, 49_999_999, clocks with no wheel pulse before DRIVE falls to WAIT
SEC_MAX, 49_999_999, clocks per second minus one
DISP_SEC, 5, seconds each display source is shown while hired

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  reset; one clock; asynchronous, active-low
stat_port  in  1  raw state button, idle high, press = low
pulse_port  in  1  raw wheel pulse, asynchronous to sys_clk
dist_pulse  out  1  one-cycle pulse per qualified wheel rising edge (hired states only)
wait_tick  out  1  one-cycle pulse per full second spent in WAIT
fare_clr  out  1  one-cycle clear of fare, distance and wait accumulators
fare_hold  out  1  freeze datapath accumulators (SETTLE)
disp_sel  out  2  00 price, 01 distance, 10 wait time
state  out  2  00 VACANT, 01 DRIVE, 10 WAIT, 11 SETTLE
stat_led  out  1  0 VACANT, 1 DRIVE/WAIT, toggles every second in SETTLE

Behaviour:
- Reset values:
  - state=VACANT; dist_pulse=0, wait_tick=0, fare_clr=0, fare_hold=0; disp_sel=00; stat_led=0.
  - All counters are 0. Debounced level is 1. Synchronizer flops are 1.
- Reset is honoured mid-operation. It aborts a trip immediately. No fare_clr is emitted on reset.
- Input sync: stat_port and pulse_port each pass through 2 flops.
- Debounce of stat_port:
  - Counter increments while the synced level differs from the stable level. It clears to 0 when they match.
  - When the counter reaches CNT_MAX, the stable level takes the synced level.
  - A stable 1->0 transition produces a one-cycle press.
  - Release generates nothing. Holding the button gives exactly one press.
- Wheel edge: pulse_rise = synced 0->1.
  - dist_pulse = pulse_rise registered (1-cycle latency), only in DRIVE or WAIT.
  - Pulses in VACANT or SETTLE are dropped.
- Idle counter:
  - Clears on pulse_rise and on entry to DRIVE. Increments otherwise while in DRIVE.
  - Reaching IDLE_TMO in DRIVE -> WAIT on the next clock.
- FSM transitions, evaluated every clock, press has priority over all other events:
  - VACANT + press -> DRIVE; fare_clr=1 for exactly the transition cycle.
  - DRIVE + press -> SETTLE.
  - DRIVE + idle timeout -> WAIT.
  - WAIT + press -> SETTLE.
  - WAIT + pulse_rise -> DRIVE. That pulse still produces dist_pulse.
  - SETTLE + press -> VACANT.
- fare_hold: 1 exactly while state==SETTLE.
- Wait second counter:
  - Cleared on entry to WAIT. Counts only in WAIT.
  - At SEC_MAX it wraps to 0 and emits wait_tick the same cycle.
  - Leaving WAIT mid-second discards the partial second; no tick is emitted.
- Free second counter:
  - Always runs and wraps at SEC_MAX, giving sec_tick.
  - Drives the stat_led toggle in SETTLE and the display rotation.
  - stat_led is 1 on SETTLE entry.
- Display rotation:
  - In DRIVE/WAIT, disp_cnt counts sec_ticks. At DISP_SEC it advances disp_sel 00->01->10->00 and clears.
  - In VACANT and SETTLE, disp_sel is forced to 00 and disp_cnt to 0.
  - Entry to DRIVE starts at 00.
- All outputs are registered.

Decomposition:
- Shared package meter_pkg holds:
  - state encodings ST_VACANT/ST_DRIVE/ST_WAIT/ST_SETTLE;
  - display codes DISP_PRICE/DISP_DIST/DISP_WAIT;
  - counter width constants derived from the parameters.
- One sub-module, key_filter: synchronizer plus debounce, output press. It is reusable for future buttons.
- The FSM, counters and display scheduler stay in meter_ctrl.

Test Plan:
Bench uses CNT_MAX=49, IDLE_TMO=999, SEC_MAX=99, DISP_SEC=2, 20 ns clock.
- Press stat_port low for 2 us with 10 bounces of 100 ns at the start -> exactly one fare_clr pulse; state 00->01; stat_led=1; release causes no event.
- In DRIVE, toggle pulse_port with period 4 us for 10 rising edges -> 10 dist_pulse pulses; state stays 01.
- Stop pulses -> state goes to 10 at 1000 clocks after the last edge; wait_tick every 100 clocks. A pulse after 250 WAIT clocks -> back to 01 with 2 ticks total, no third.
- Press while in WAIT -> state 11, fare_hold=1, disp_sel=00, stat_led toggles every 100 clocks, wheel pulses give no dist_pulse; press again -> state 00, fare_hold=0.
- Hired for 700 clocks -> disp_sel sequence 00,01,10,00 with changes every 200 clocks.
- Assert sys_rst_n low mid-WAIT asynchronously -> all outputs return to reset values within the same cycle; no fare_clr emitted. Press arriving in the same cycle as the idle timeout -> SETTLE, not WAIT.
